// File: rtl/fxp_int_adder.sv
// ---------------------------------------------------------------------------
// FxpIntAdder : registered two-operand fixed-point / integer adder
//
// Adds two operands that each carry their own signedness, width and fraction
// count, and converts the exact sum into the output format. The binary points
// are aligned first, the sum is formed at full precision, surplus fraction
// bits are dropped by flooring, and the result is saturated to the output
// range. One register stage, so results appear one cycle after in_valid.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset (overrides in_valid)
//   in_valid   : operands in1/in2 are valid this cycle
//   in1        : operand 1, I1_PREC bits, I1_FRAC fraction bits
//   in2        : operand 2, I2_PREC bits, I2_FRAC fraction bits
//   out_valid  : out and the flags hold a fresh result
//   out        : saturated, floored sum, O_PREC bits, O_FRAC fraction bits
//   ovf        : sum was above the largest output value (out = max)
//   udf        : sum was below the smallest output value (out = min)
//   rounded    : nonzero fraction bits were discarded
// ---------------------------------------------------------------------------
module fxp_int_adder #(
  parameter int TYPE    = 1,
  parameter int I1_SIGN = 1,
  parameter int I1_PREC = 8,
  parameter int I1_FRAC = 3,
  parameter int I2_SIGN = 1,
  parameter int I2_PREC = 16,
  parameter int I2_FRAC = 4,
  parameter int O_SIGN  = ((I1_SIGN != 0) || (I2_SIGN != 0)) ? 1 : 0,
  parameter int O_PREC  = (I1_PREC > I2_PREC) ? I1_PREC : I2_PREC,
  parameter int O_FRAC  = (I1_FRAC > I2_FRAC) ? I1_FRAC : I2_FRAC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [I1_PREC-1:0] in1,
  input  logic [I2_PREC-1:0] in2,
  output logic               out_valid,
  output logic [O_PREC-1:0]  out,
  output logic               ovf,
  output logic               udf,
  output logic               rounded
);

  // In integer mode every fraction count collapses to zero, which turns the
  // whole datapath into a plain saturating integer adder.
  localparam int I1F = (TYPE != 0) ? I1_FRAC : 0;
  localparam int I2F = (TYPE != 0) ? I2_FRAC : 0;
  localparam int OF  = (TYPE != 0) ? O_FRAC  : 0;

  // Common fraction count that every operand is brought up to.
  localparam int F12 = (I1F > I2F) ? I1F : I2F;
  localparam int FW  = (F12 > OF) ? F12 : OF;

  localparam int SH1 = FW - I1F;
  localparam int SH2 = FW - I2F;
  localparam int A1W = I1_PREC + SH1;
  localparam int A2W = I2_PREC + SH2;

  // Two guard bits: one for the carry of the addition, one so that an
  // unsigned operand still has a zero sign bit inside the signed word.
  localparam int SW  = ((A1W > A2W) ? A1W : A2W) + 2;

  localparam int RSH = FW - OF;

  // Comparison width must hold both the reduced sum and the output limits.
  localparam int CW  = (SW > O_PREC + 2) ? SW : O_PREC + 2;

  localparam logic signed [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] MAXV = (O_SIGN != 0) ? (ONE <<< (O_PREC - 1)) - ONE
                                                        : (ONE <<< O_PREC) - ONE;
  localparam logic signed [CW-1:0] MINV = (O_SIGN != 0) ? -(ONE <<< (O_PREC - 1))
                                                        : {CW{1'b0}};

  logic signed [SW-1:0] ext1;
  logic signed [SW-1:0] ext2;
  logic signed [SW-1:0] aligned1;
  logic signed [SW-1:0] aligned2;
  logic signed [SW-1:0] sumFull;
  logic signed [SW-1:0] reduced;
  logic signed [CW-1:0] reducedWide;
  logic                 dropped;

  logic              outValid_d, outValid_q;
  logic [O_PREC-1:0] out_d, out_q;
  logic              ovf_d, ovf_q;
  logic              udf_d, udf_q;
  logic              rounded_d, rounded_q;

  // Widen each operand into the signed working word: the fill bit is the
  // operand MSB only when that operand is declared signed.
  assign ext1 = {{(SW - I1_PREC){in1[I1_PREC-1] & (I1_SIGN != 0)}}, in1};
  assign ext2 = {{(SW - I2_PREC){in2[I2_PREC-1] & (I2_SIGN != 0)}}, in2};

  // Line up the binary points; the guard bits guarantee nothing falls off.
  assign aligned1 = ext1 <<< SH1;
  assign aligned2 = ext2 <<< SH2;
  assign sumFull  = aligned1 + aligned2;

  // Drop surplus fraction bits. An arithmetic right shift of a two's
  // complement value floors toward minus infinity, which is the intended
  // rounding; any nonzero shifted-out bit raises the rounded flag.
  generate
    if (RSH > 0) begin : g_reduce
      assign reduced = sumFull >>> RSH;
      assign dropped = |sumFull[RSH-1:0];
    end else begin : g_exact
      assign reduced = sumFull;
      assign dropped = 1'b0;
    end
  endgenerate

  assign reducedWide = CW'(reduced);

  // Range check and saturation. The result is captured only when in_valid is
  // high; otherwise the previous result and flags are held.
  always_comb begin
    outValid_d = in_valid;
    out_d      = out_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rounded_d  = rounded_q;
    if (in_valid) begin
      out_d     = reducedWide[O_PREC-1:0];
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      rounded_d = dropped;
      if (reducedWide > MAXV) begin
        out_d = MAXV[O_PREC-1:0];
        ovf_d = 1'b1;
      end else if (reducedWide < MINV) begin
        out_d = MINV[O_PREC-1:0];
        udf_d = 1'b1;
      end
    end
  end

  // Single output register stage; reset clears the result and all flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rounded_q  <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rounded_q  <= rounded_d;
    end
  end

  assign out_valid = outValid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign rounded   = rounded_q;

endmodule

// File: tb/tb_fxp_int_adder.sv
// ---------------------------------------------------------------------------
// Testbench for FxpIntAdder. Four instances share clock and reset:
//   A : default FXP configuration (s8.3 + s16.4 -> s16.4)
//   B : as A but with O_FRAC = 2, so fraction bits are floored away
//   C : INT mode, all widths 8
//   D : mixed signedness with an unsigned output (u8.2 + s12.5 -> u10.3)
// Directed vectors cover the worked examples, then random operands are
// compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fxp_int_adder;

  logic clk;
  logic reset;

  logic        inValidA, inValidB, inValidC, inValidD;
  logic [7:0]  in1A, in1B, in1C, in1D;
  logic [15:0] in2A, in2B;
  logic [7:0]  in2C;
  logic [11:0] in2D;

  logic        outValidA, outValidB, outValidC, outValidD;
  logic [15:0] outA, outB;
  logic [7:0]  outC;
  logic [9:0]  outD;
  logic        ovfA, ovfB, ovfC, ovfD;
  logic        udfA, udfB, udfC, udfD;
  logic        rndA, rndB, rndC, rndD;

  int assertCount;
  int failCount;

  fxp_int_adder dutA (
    .clk(clk), .reset(reset), .in_valid(inValidA), .in1(in1A), .in2(in2A),
    .out_valid(outValidA), .out(outA), .ovf(ovfA), .udf(udfA), .rounded(rndA)
  );

  fxp_int_adder #(.O_FRAC(2)) dutB (
    .clk(clk), .reset(reset), .in_valid(inValidB), .in1(in1B), .in2(in2B),
    .out_valid(outValidB), .out(outB), .ovf(ovfB), .udf(udfB), .rounded(rndB)
  );

  fxp_int_adder #(.TYPE(0), .I1_PREC(8), .I2_PREC(8), .O_PREC(8)) dutC (
    .clk(clk), .reset(reset), .in_valid(inValidC), .in1(in1C), .in2(in2C),
    .out_valid(outValidC), .out(outC), .ovf(ovfC), .udf(udfC), .rounded(rndC)
  );

  fxp_int_adder #(.TYPE(1), .I1_SIGN(0), .I1_PREC(8), .I1_FRAC(2),
                  .I2_SIGN(1), .I2_PREC(12), .I2_FRAC(5),
                  .O_SIGN(0), .O_PREC(10), .O_FRAC(3)) dutD (
    .clk(clk), .reset(reset), .in_valid(inValidD), .in1(in1D), .in2(in2D),
    .out_valid(outValidD), .out(outD), .ovf(ovfD), .udf(udfD), .rounded(rndD)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Reference: interpret operands as real-valued numbers scaled by a common
  // power of two, add, floor-divide down to the output scale, then clamp.
  function automatic void refAdd(
    input int typ, input int s1, input int p1, input int f1,
    input int s2, input int p2, input int f2,
    input int so, input int po, input int fo,
    input longint a, input longint b,
    output longint o, output bit ov, output bit ud, output bit rd);
    longint v1, v2, scaled, divisor, q, r, maxv, minv;
    int     fMax;
    if (typ == 0) begin
      f1 = 0;
      f2 = 0;
      fo = 0;
    end
    v1 = (s1 != 0 && a >= (longint'(1) << (p1 - 1))) ? a - (longint'(1) << p1) : a;
    v2 = (s2 != 0 && b >= (longint'(1) << (p2 - 1))) ? b - (longint'(1) << p2) : b;
    fMax = f1;
    if (f2 > fMax) fMax = f2;
    if (fo > fMax) fMax = fo;
    scaled  = v1 * (longint'(1) << (fMax - f1)) + v2 * (longint'(1) << (fMax - f2));
    divisor = longint'(1) << (fMax - fo);
    q = scaled / divisor;
    r = scaled % divisor;
    if (r != 0 && scaled < 0) q = q - 1;
    rd   = (r != 0);
    maxv = (so != 0) ? (longint'(1) << (po - 1)) - 1 : (longint'(1) << po) - 1;
    minv = (so != 0) ? -(longint'(1) << (po - 1)) : 0;
    ov = 1'b0;
    ud = 1'b0;
    if (q > maxv) begin
      q  = maxv;
      ov = 1'b1;
    end else if (q < minv) begin
      q  = minv;
      ud = 1'b1;
    end
    o = q & ((longint'(1) << po) - 1);
  endfunction

  // Drive one operand pair into the selected instance (which < 0 means an
  // idle cycle for everyone), then step past the sampling edge.
  task automatic applyStimulus(input int which, input longint a, input longint b);
    inValidA = 1'b0;
    inValidB = 1'b0;
    inValidC = 1'b0;
    inValidD = 1'b0;
    case (which)
      0: begin inValidA = 1'b1; in1A = a[7:0]; in2A = b[15:0]; end
      1: begin inValidB = 1'b1; in1B = a[7:0]; in2B = b[15:0]; end
      2: begin inValidC = 1'b1; in1C = a[7:0]; in2C = b[7:0];  end
      3: begin inValidD = 1'b1; in1D = a[7:0]; in2D = b[11:0]; end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Compare the selected instance against the reference model.
  task automatic checkDut(input int which, input longint a, input longint b);
    longint o;
    bit ov, ud, rd;
    case (which)
      0: begin
        refAdd(1, 1, 8, 3, 1, 16, 4, 1, 16, 4, a, b, o, ov, ud, rd);
        checkOutput("A.valid", longint'(outValidA), 1);
        checkOutput("A.out", longint'(outA), o);
        checkOutput("A.ovf", longint'(ovfA), longint'(ov));
        checkOutput("A.udf", longint'(udfA), longint'(ud));
        checkOutput("A.rounded", longint'(rndA), longint'(rd));
      end
      1: begin
        refAdd(1, 1, 8, 3, 1, 16, 4, 1, 16, 2, a, b, o, ov, ud, rd);
        checkOutput("B.valid", longint'(outValidB), 1);
        checkOutput("B.out", longint'(outB), o);
        checkOutput("B.ovf", longint'(ovfB), longint'(ov));
        checkOutput("B.udf", longint'(udfB), longint'(ud));
        checkOutput("B.rounded", longint'(rndB), longint'(rd));
      end
      2: begin
        refAdd(0, 1, 8, 3, 1, 8, 4, 1, 8, 4, a, b, o, ov, ud, rd);
        checkOutput("C.valid", longint'(outValidC), 1);
        checkOutput("C.out", longint'(outC), o);
        checkOutput("C.ovf", longint'(ovfC), longint'(ov));
        checkOutput("C.udf", longint'(udfC), longint'(ud));
        checkOutput("C.rounded", longint'(rndC), longint'(rd));
      end
      default: begin
        refAdd(1, 0, 8, 2, 1, 12, 5, 0, 10, 3, a, b, o, ov, ud, rd);
        checkOutput("D.valid", longint'(outValidD), 1);
        checkOutput("D.out", longint'(outD), o);
        checkOutput("D.ovf", longint'(ovfD), longint'(ov));
        checkOutput("D.udf", longint'(udfD), longint'(ud));
        checkOutput("D.rounded", longint'(rndD), longint'(rd));
      end
    endcase
  endtask

  // Main sequence: reset, directed vectors, hold/reset behaviour, random.
  initial begin
    assertCount = 0;
    failCount   = 0;
    reset    = 1'b1;
    inValidA = 1'b0; inValidB = 1'b0; inValidC = 1'b0; inValidD = 1'b0;
    in1A = '0; in2A = '0; in1B = '0; in2B = '0;
    in1C = '0; in2C = '0; in1D = '0; in2D = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.A.valid", longint'(outValidA), 0);
    checkOutput("reset.A.out", longint'(outA), 0);
    checkOutput("reset.D.out", longint'(outD), 0);
    checkOutput("reset.C.flags", longint'({ovfC, udfC, rndC}), 0);
    reset = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus(0, 'h1C, 'h0020);
    checkOutput("A.3p5+2", longint'(outA), 'h0058);
    checkOutput("A.3p5+2.flags", longint'({ovfA, udfA, rndA}), 0);
    checkOutput("A.3p5+2.valid", longint'(outValidA), 1);

    applyStimulus(0, 'h7C, 'h01F2);
    checkOutput("A.15p5+31p125", longint'(outA), 'h02EA);
    checkOutput("A.15p5+31p125.flags", longint'({ovfA, udfA, rndA}), 0);

    applyStimulus(0, 'h7F, 'h7FFF);
    checkOutput("A.sat.max", longint'(outA), 'h7FFF);
    checkOutput("A.sat.ovf", longint'(ovfA), 1);
    checkOutput("A.sat.udf", longint'(udfA), 0);

    applyStimulus(0, 'h80, 'h8000);
    checkOutput("A.sat.min", longint'(outA), 'h8000);
    checkOutput("A.sat.udf2", longint'(udfA), 1);
    checkOutput("A.sat.ovf2", longint'(ovfA), 0);

    applyStimulus(1, 'h01, 'h0000);
    checkOutput("B.floor.out", longint'(outB), 0);
    checkOutput("B.floor.rounded", longint'(rndB), 1);
    applyStimulus(1, 'h02, 'h0000);
    checkOutput("B.exact.out", longint'(outB), 1);
    checkOutput("B.exact.rounded", longint'(rndB), 0);

    applyStimulus(2, 3, 2);
    checkOutput("C.3+2", longint'(outC), 5);
    checkOutput("C.3+2.flags", longint'({ovfC, udfC, rndC}), 0);
    applyStimulus(2, 100, 100);
    checkOutput("C.ovf.out", longint'(outC), 127);
    checkOutput("C.ovf.flag", longint'(ovfC), 1);
    applyStimulus(2, 'h9C, 'h9C);
    checkOutput("C.udf.out", longint'(outC), 'h80);
    checkOutput("C.udf.flag", longint'(udfC), 1);

    // Unsigned output with a negative sum: 0.25 + (-1.0) clamps to zero.
    applyStimulus(3, 'h01, 'hFE0);
    checkOutput("D.neg.out", longint'(outD), 0);
    checkOutput("D.neg.udf", longint'(udfD), 1);

    $display("[TB] hold and reset behaviour");
    applyStimulus(0, 'h1C, 'h0020);
    applyStimulus(-1, 0, 0);
    checkOutput("hold.valid", longint'(outValidA), 0);
    checkOutput("hold.out", longint'(outA), 'h0058);

    applyStimulus(0, 'h7F, 'h7FFF);
    checkOutput("prereset.ovf", longint'(ovfA), 1);
    reset    = 1'b1;
    inValidA = 1'b1;
    in1A     = 8'h1C;
    in2A     = 16'h0020;
    @(posedge clk);
    #1;
    checkOutput("midreset.valid", longint'(outValidA), 0);
    checkOutput("midreset.out", longint'(outA), 0);
    checkOutput("midreset.flags", longint'({ovfA, udfA, rndA}), 0);
    reset    = 1'b0;
    inValidA = 1'b0;

    $display("[TB] random vectors");
    for (int i = 0; i < 1000; i++) begin
      int     which;
      longint a, b;
      which = i % 4;
      a = longint'($urandom_range(0, 255));
      case (which)
        0, 1:    b = longint'($urandom_range(0, 65535));
        2:       b = longint'($urandom_range(0, 255));
        default: b = longint'($urandom_range(0, 4095));
      endcase
      applyStimulus(which, a, b);
      checkDut(which, a, b);
    end

    applyStimulus(-1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fxp_int_adder.md
Name: fxp_int_adder

Overview:
- Registered two-operand adder for the perceptron datapath; each operand and the result have their own sign, precision and fraction settings.
- Serves as the synthesizable counterpart of the bench-side FxpCalc/IntCalc add reference models and the FxpUtils encode/decode helpers.
- Aligns the binary points, adds at full precision, then converts to the output format, flagging overflow, underflow and rounding.
- One-cycle latency with a valid qualifier; sits between multiply/accumulate stages.

Parameters:
- TYPE, 1, number format: 0 = INT (all FRAC values forced to 0), 1 = FXP.
- I1_SIGN, 1, 1 = in1 is two's-complement signed, 0 = unsigned.
- I1_PREC, 8, in1 width in bits.
- I1_FRAC, 3, in1 fraction bits.
- I2_SIGN, 1, signedness of in2.
- I2_PREC, 16, in2 width.
- I2_FRAC, 4, in2 fraction bits.
- O_SIGN, I1_SIGN|I2_SIGN, signedness of out.
- O_PREC, max(I1_PREC,I2_PREC), out width.
- O_FRAC, max(I1_FRAC,I2_FRAC), out fraction bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- in1  input  I1_PREC  operand 1.
- in2  input  I2_PREC  operand 2.
- out_valid  output  1  result valid.
- out  output  O_PREC  saturated/rounded sum.
- ovf  output  1  result exceeded the maximum representable output value.
- udf  output  1  result fell below the minimum representable output value.
- rounded  output  1  nonzero fraction bits were discarded.

Behaviour:
- Reset: out_valid, out, ovf, udf and rounded all register to 0 on the first rising edge with reset=1. Reset overrides in_valid.
- Latency: values sampled on edge N (in_valid=1) appear on out/flags with out_valid=1 after edge N. With in_valid=0, out_valid=0 next cycle and out/flags hold their previous values. New operands are accepted every cycle; there is no stall.
- Extension: each input is sign-extended if its SIGN=1, otherwise zero-extended.
- Alignment: F = max(I1_FRAC, I2_FRAC, O_FRAC). Each operand is left-shifted by F minus its own FRAC.
- Sum width: computed exactly in a signed internal word of width max(aligned widths)+2; the sum never wraps internally.
- Fraction reduction:
  - If O_FRAC < F, shift the sum right by F-O_FRAC, truncating toward minus infinity (floor).
  - rounded=1 iff any discarded bit is nonzero; otherwise rounded=0.
- Range check after reduction, against the output range:
  - Signed out: -2^(O_PREC-1) .. 2^(O_PREC-1)-1.
  - Unsigned out: 0 .. 2^O_PREC-1.
  - Above max: out = max, ovf=1. Below min: out = min, udf=1. ovf and udf are never both 1.
  - When ovf or udf is set, rounded still reports whether bits were dropped.
- In range: out is the exact value in O_FRAC format; ovf=udf=0.
- Unsigned output with a negative sum: udf=1, out=0.
- INT mode: identical datapath with all FRAC values treated as 0, so rounded is always 0.
- Purely combinational datapath followed by a single register stage. No state machine.

Test Plan:
- Default FXP configuration, in1=8'h1C (3.5), in2=16'h0020 (2.0) -> next cycle out=16'h0058 (5.5), ovf=udf=rounded=0, out_valid=1.
- in1=8'h7C (15.5), in2=16'h01F2 (31.125) -> out=16'h02EA (46.625), all flags 0.
- in1=8'h7F, in2=16'h7FFF -> out=16'h7FFF, ovf=1. Then in1=8'h80, in2=16'h8000 -> out=16'h8000, udf=1.
- Instance with O_FRAC=2, in1=8'h01 (0.125), in2=16'h0000 -> out=0, rounded=1. Then in1=8'h02 (0.25) -> out=16'h0001, rounded=0.
- TYPE=INT, all PREC=8, FRAC=0: 3+2 -> 5. 100+100 -> 127 with ovf. -100+-100 -> -128 with udf.
- Assert reset while out_valid=1 -> outputs and flags 0 on the next edge. in_valid=0 -> out_valid=0, out held. 1000 random operand pairs -> out matches a floor-and-saturate reference model, with flags consistent.
